fnd_scan_decoder: RTL and testbench
===================================

FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning the number of consecutive identical cycles required before a digit is captured (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 2_000_000, meaning the cycles without a valid frame before stale asserts.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seg, input, 8 bits: active-low segment bus, dp = bit 7, as driven by the FND scan driver.
REQ-006 SHALL have port seg_comm, input, 4 bits: active-low digit enables.
REQ-007 SHALL have port bcd_msec, output, 7 bits: last valid reconstructed msec value, 0..99.
REQ-008 SHALL have port bcd_sec, output, 6 bits: last valid reconstructed sec value, 0..59.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when bcd_msec/bcd_sec update.
REQ-010 SHALL have ports seg_err, comm_err and range_err, each output, 1 bit: one-cycle error pulses.
REQ-011 SHALL have port stale, output, 1 bit: level, high when no frame has been seen for TIMEOUT cycles.

Function
REQ-012 SHALL register seg and seg_comm once on input; all decisions use the registered copies (1 cycle input latency).
REQ-013 SHALL map seg_comm as follows: 4'b1110 = digit0 (msec ones), 4'b1101 = digit1 (msec tens), 4'b1011 = digit2 (sec ones), 4'b0111 = digit3 (sec tens), 4'b1111 = blank (ignored, no error).
REQ-014 SHALL pulse comm_err for one cycle on capture of any seg_comm value other than those in REQ-013, with no digit captured.
REQ-015 SHALL decode seg as follows: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E map to 0..F; any other code pulses seg_err for one cycle at capture, with no digit captured.
REQ-016 SHALL implement the FSM S_TRACK -> S_HOLD -> S_COMMIT:
- S_TRACK: stability counter increments while the registered (seg, seg_comm) equals the previous cycle's value, and clears to 0 on any change; at count SETTLE-1, capture the digit and go to S_HOLD.
- S_HOLD: no further capture; any change in seg or seg_comm clears the counter and returns to S_TRACK.
REQ-017 SHALL, on capture, store the nibble in that digit's slot and set its bit in a 4-bit capture mask; recapturing a digit already in the mask overwrites the slot.
REQ-018 SHALL, when the mask becomes 4'b1111, enter S_COMMIT for exactly one cycle, clear the mask, and then return to S_HOLD.
REQ-019 SHALL, in S_COMMIT, check that digits 0..2 are <= 9 and digit3 is <= 5; if the check passes, load bcd_msec = d1*10+d0 and bcd_sec = d3*10+d2 and pulse frame_valid.
REQ-020 SHALL, if the check in REQ-019 fails, pulse range_err and leave the outputs unchanged.
REQ-021 SHALL have a total latency of 1 cycle from the capture that completes the mask to the frame_valid pulse, with the outputs updating on the same edge as frame_valid.
REQ-022 SHALL run a timeout counter that clears on frame_valid and saturates; stale goes high when the counter reaches TIMEOUT-1 and goes low on the cycle frame_valid pulses.
REQ-023 SHALL treat a seg change and a seg_comm change in the same cycle as a single change.
REQ-024 SHALL never pulse an error and frame_valid in the same cycle.

Reset
REQ-025 SHALL, while reset is high at a clock edge, set bcd_msec=0, bcd_sec=0, frame_valid=0, all error pulses=0, stale=0, mask=0, counters=0, state=S_TRACK, and input registers seg=8'hFF and seg_comm=4'hF.
REQ-026 SHALL, on reset asserted mid-frame, discard partial captures; a complete new 4-digit frame is then required.

Structure
REQ-027 SHALL place the segment code constants, seg_comm digit codes, digit indices and FSM state encodings in a shared package fnd_pkg.
REQ-028 SHALL contain one sub-module, seg_to_bcd: a combinational inverse of the segment table, with outputs nibble[3:0] and valid.

Verification
REQ-029 SHALL cover: with SETTLE=4, dwell of 8 cycles each on 1110/99, 1101/B0, 1011/A4, 0111/F9 -> one frame_valid pulse, bcd_msec=34, bcd_sec=12.
REQ-030 SHALL cover: a 2-cycle dwell on 1110/C0 inside a stable frame -> no capture and no frame_valid from it.
REQ-031 SHALL cover: digit1 driven with seg=8'hFF -> seg_err pulse, no frame_valid, outputs retain 34/12.
REQ-032 SHALL cover: digit3 driven with 82 (value 6) in an otherwise valid frame -> range_err pulse, outputs unchanged.
REQ-033 SHALL cover: seg_comm=4'b1100 held for 8 cycles -> one comm_err pulse.
REQ-034 SHALL cover: reset after 2 captured digits, then 2 more digits -> no frame_valid; with TIMEOUT=100 and no frames -> stale=1 at cycle 100, cleared by the next valid frame.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan decoder.
// Holds the active-low segment codes for hex 0..F, the seg_comm digit-enable
// codes, the digit slot indices and the decoder FSM state encoding.
package fnd_pkg;

  // Active-low 7-segment codes (dp = bit 7, always off) for nibble values 0..F
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  // Active-low digit enables
  localparam logic [3:0] COMM_D0    = 4'b1110;
  localparam logic [3:0] COMM_D1    = 4'b1101;
  localparam logic [3:0] COMM_D2    = 4'b1011;
  localparam logic [3:0] COMM_D3    = 4'b0111;
  localparam logic [3:0] COMM_BLANK = 4'b1111;

  // Digit slot indices
  localparam logic [1:0] DIG_MS_ONES = 2'd0;
  localparam logic [1:0] DIG_MS_TENS = 2'd1;
  localparam logic [1:0] DIG_S_ONES  = 2'd2;
  localparam logic [1:0] DIG_S_TENS  = 2'd3;

  // Stability counter width (covers SETTLE up to 255)
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_TRACK  = 2'd0,
    S_HOLD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/fnd_scan_decoder_seg_to_bcd.sv
// seg_to_bcd: combinational inverse of the active-low 7-segment table.
// Ports:
//   seg    in  [7:0] active-low segment code (dp = bit 7)
//   nibble out [3:0] decoded value 0..F (0 when not valid)
//   valid  out       high when seg is one of the 16 known codes
module seg_to_bcd
  import fnd_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: reconstructs the sec/msec value shown on a 4-digit
// multiplexed FND by sniffing the scan driver's segment and digit-enable buses.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   seg[7:0]            active-low segment bus (dp = bit 7)
//   seg_comm[3:0]       active-low digit enables
//   bcd_msec[6:0]       last valid msec value 0..99
//   bcd_sec[5:0]        last valid sec value 0..59
//   frame_valid         one-cycle pulse when bcd_msec/bcd_sec update
//   seg_err/comm_err/range_err  one-cycle error pulses
//   stale               high when no valid frame for TIMEOUT cycles
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg,
  input  logic [3:0] seg_comm,
  output logic [6:0] bcd_msec,
  output logic [5:0] bcd_sec,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       comm_err,
  output logic       range_err,
  output logic       stale
);

  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] ST_MAX  = CNT_W'(SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_PRE  = TO_W'(TIMEOUT - 2);

  logic [7:0]       seg_q, seg_p;
  logic [3:0]       comm_q, comm_p;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       mask;
  logic [3:0][3:0]  digits;
  state_t           state;

  logic       changed_c;
  logic [1:0] dig_idx_c;
  logic       comm_ok_c;
  logic       comm_blank_c;
  logic [3:0] mask_set_c;
  logic [3:0] nib_c;
  logic       seg_ok_c;
  logic       range_ok_c;

  seg_to_bcd u_seg_to_bcd (
    .seg    (seg_q),
    .nibble (nib_c),
    .valid  (seg_ok_c)
  );

  // A seg and seg_comm change in the same cycle count as one change
  assign changed_c  = (seg_q != seg_p) || (comm_q != comm_p);
  assign mask_set_c = mask | (4'b0001 << dig_idx_c);
  assign range_ok_c = (digits[DIG_MS_ONES] <= 4'd9) && (digits[DIG_MS_TENS] <= 4'd9) &&
                      (digits[DIG_S_ONES]  <= 4'd9) && (digits[DIG_S_TENS]  <= 4'd5);

  // Digit-enable decode; blank is legal but carries no digit
  always_comb begin
    dig_idx_c    = DIG_MS_ONES;
    comm_ok_c    = 1'b1;
    comm_blank_c = 1'b0;
    case (comm_q)
      COMM_D0:    dig_idx_c    = DIG_MS_ONES;
      COMM_D1:    dig_idx_c    = DIG_MS_TENS;
      COMM_D2:    dig_idx_c    = DIG_S_ONES;
      COMM_D3:    dig_idx_c    = DIG_S_TENS;
      COMM_BLANK: comm_blank_c = 1'b1;
      default:    comm_ok_c    = 1'b0;
    endcase
  end

  // Input capture, settle FSM, frame commit and staleness timer
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q       <= 8'hFF;
      comm_q      <= 4'hF;
      seg_p       <= 8'hFF;
      comm_p      <= 4'hF;
      cnt         <= '0;
      to_cnt      <= '0;
      mask        <= '0;
      digits      <= '0;
      state       <= S_TRACK;
      bcd_msec    <= '0;
      bcd_sec     <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      comm_err    <= 1'b0;
      range_err   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      seg_q       <= seg;
      comm_q      <= seg_comm;
      seg_p       <= seg_q;
      comm_p      <= comm_q;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      comm_err    <= 1'b0;
      range_err   <= 1'b0;

      case (state)
        S_TRACK: begin
          if (changed_c) begin
            cnt <= '0;
          end else if (cnt == ST_MAX) begin
            cnt   <= '0;
            state <= S_HOLD;
            // Digit-enable errors take priority over segment errors
            if (comm_blank_c) begin
              cnt <= '0;
            end else if (!comm_ok_c) begin
              comm_err <= 1'b1;
            end else if (!seg_ok_c) begin
              seg_err <= 1'b1;
            end else begin
              digits[dig_idx_c] <= nib_c;
              mask              <= mask_set_c;
              if (mask_set_c == 4'hF) begin
                state <= S_COMMIT;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (changed_c) begin
            cnt   <= '0;
            state <= S_TRACK;
          end
        end
        S_COMMIT: begin
          mask <= '0;
          cnt  <= '0;
          // A change landing on the commit cycle must still restart tracking
          state <= changed_c ? S_TRACK : S_HOLD;
          if (range_ok_c) begin
            bcd_msec    <= 7'(digits[DIG_MS_TENS]) * 7'd10 + 7'(digits[DIG_MS_ONES]);
            bcd_sec     <= 6'(digits[DIG_S_TENS]) * 6'd10 + 6'(digits[DIG_S_ONES]);
            frame_valid <= 1'b1;
          end else begin
            range_err <= 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_TRACK;
        end
      endcase

      // Saturating staleness timer, cleared by each accepted frame
      if (state == S_COMMIT && range_ok_c) begin
        to_cnt <= '0;
        stale  <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (to_cnt == TO_PRE) begin
          stale <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: directed scenarios plus randomized dwell
// sequences, checked against a dwell-level reference model.
module tb_fnd_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seg = 8'hFF;
  logic [3:0] seg_comm = 4'hF;
  logic [6:0] bcd_msec;
  logic [5:0] bcd_sec;
  logic       frame_valid, seg_err, comm_err, range_err, stale;

  fnd_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .seg_comm    (seg_comm),
    .bcd_msec    (bcd_msec),
    .bcd_sec     (bcd_sec),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .comm_err    (comm_err),
    .range_err   (range_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulse counters
  int n_fv = 0, n_seg = 0, n_comm = 0, n_range = 0, n_both = 0, last_fv_cyc = -1;
  always @(negedge clk) begin
    if (frame_valid) begin
      n_fv++;
      last_fv_cyc = cyc;
    end
    if (seg_err)   n_seg++;
    if (comm_err)  n_comm++;
    if (range_err) n_range++;
    if (frame_valid && (seg_err || comm_err || range_err)) n_both++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference model state
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int e_fv = 0, e_seg = 0, e_comm = 0, e_range = 0;
  int e_msec = 0, e_sec = 0;
  int m_mask = 0;
  int m_dig [4] = '{0, 0, 0, 0};
  logic [3:0] last_c = 4'hF;
  logic [7:0] last_s = 8'hFF;
  int last_start = 0;

  function automatic int seg_value(input logic [7:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  // Digit number for an enable pattern; -2 = blank, -1 = illegal
  function automatic int comm_digit(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      4'b1111: return -2;
      default: return -1;
    endcase
  endfunction

  // One dwell of n cycles on (c, s): captured only if held SETTLE cycles
  // beyond its first appearance
  task automatic model_dwell(input logic [3:0] c, input logic [7:0] s, input int n);
    int d, v;
    if (n < int'(SETTLE) + 1) return;
    d = comm_digit(c);
    if (d == -2) return;
    if (d < 0) begin e_comm++; return; end
    v = seg_value(s);
    if (v < 0) begin e_seg++; return; end
    m_dig[d] = v;
    m_mask |= (1 << d);
    if (m_mask == 15) begin
      m_mask = 0;
      if (m_dig[0] < 10 && m_dig[1] < 10 && m_dig[2] < 10 && m_dig[3] < 6) begin
        e_fv++;
        e_msec = m_dig[1] * 10 + m_dig[0];
        e_sec  = m_dig[3] * 10 + m_dig[2];
      end else begin
        e_range++;
      end
    end
  endtask

  task automatic apply(input logic [3:0] c, input logic [7:0] s, input int n);
    seg_comm   = c;
    seg        = s;
    last_start = cyc;
    repeat (n) @(posedge clk);
    #1;
    model_dwell(c, s, n);
    last_c = c;
    last_s = s;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    seg_comm = 4'hF;
    seg      = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    m_mask = 0;
    e_msec = 0;
    e_sec  = 0;
    last_c = 4'hF;
    last_s = 8'hFF;
  endtask

  // Let any in-flight capture/commit drain on a blank display
  task automatic flush();
    if (last_c == 4'hF && last_s == 8'hFF) begin
      repeat (SETTLE + 4) @(posedge clk);
      #1;
    end else begin
      apply(4'hF, 8'hFF, SETTLE + 4);
    end
  endtask

  task automatic check_all(input string tag);
    flush();
    check_eq({tag, "_fv"},    n_fv,     e_fv);
    check_eq({tag, "_segerr"}, n_seg,   e_seg);
    check_eq({tag, "_commerr"}, n_comm, e_comm);
    check_eq({tag, "_rangeerr"}, n_range, e_range);
    check_eq({tag, "_msec"},  int'(bcd_msec), e_msec);
    check_eq({tag, "_sec"},   int'(bcd_sec),  e_sec);
  endtask

  task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    apply(4'b1110, s0, 8);
    apply(4'b1101, s1, 8);
    apply(4'b1011, s2, 8);
    apply(4'b0111, s3, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, fv_start, r;
    logic [3:0] c;
    logic [7:0] s;

    @(posedge clk);
    #1;
    do_reset();
    check_eq("rst_msec", int'(bcd_msec), 0);
    check_eq("rst_sec", int'(bcd_sec), 0);
    check_eq("rst_fv", int'(frame_valid), 0);
    check_eq("rst_errs", int'({seg_err, comm_err, range_err}), 0);
    check_eq("rst_stale", int'(stale), 0);

    // 34/12 frame and its commit latency
    frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    fv_start = last_start;
    check_all("frame1");
    check_eq("frame1_msec34", int'(bcd_msec), 34);
    check_eq("frame1_sec12", int'(bcd_sec), 12);
    check_eq("frame1_latency", last_fv_cyc - fv_start, int'(SETTLE) + 3);

    // Short glitch on digit0 must not be captured
    apply(4'b1110, 8'h99, 8);
    apply(4'b1101, 8'hB0, 8);
    apply(4'b1110, 8'hC0, 2);
    apply(4'b1011, 8'hA4, 8);
    apply(4'b0111, 8'hF9, 8);
    check_all("glitch");
    check_eq("glitch_msec34", int'(bcd_msec), 34);

    // Unknown segment code on digit1
    frame(8'h99, 8'hFF, 8'hA4, 8'hF9);
    check_all("segerr");
    check_eq("segerr_msec34", int'(bcd_msec), 34);
    apply(4'b1101, 8'hB0, 8);
    check_all("segerr_close");

    // Sec tens = 6 is out of range
    frame(8'h92, 8'hB0, 8'hA4, 8'h82);
    check_all("range");
    check_eq("range_sec12", int'(bcd_sec), 12);

    // Two digits enabled at once
    apply(4'b1100, 8'h99, 8);
    check_all("comm");

    // Reset mid-frame drops partial captures
    apply(4'b1110, 8'h99, 8);
    apply(4'b1101, 8'hB0, 8);
    do_reset();
    rel = cyc;
    apply(4'b1011, 8'hA4, 8);
    apply(4'b0111, 8'hF9, 8);
    check_all("midreset");
    check_eq("midreset_msec0", int'(bcd_msec), 0);

    // Staleness after TIMEOUT cycles without frames
    while (cyc < rel + int'(TIMEOUT) - 4) @(posedge clk);
    #1;
    check_eq("stale_early", int'(stale), 0);
    while (cyc < rel + int'(TIMEOUT) + 1) @(posedge clk);
    #1;
    check_eq("stale_set", int'(stale), 1);
    frame(8'h90, 8'h92, 8'h92, 8'h92);
    check_all("stale_clear");
    check_eq("stale_cleared", int'(stale), 0);

    // Randomized dwell sequences
    for (int b = 0; b < 25; b++) begin
      for (int k = 0; k < 8; k++) begin
        do begin
          r = $urandom_range(0, 9);
          if (r < 7)       c = 4'(4'b1111 & ~(4'b0001 << (r % 4)));
          else if (r == 7) c = 4'hF;
          else             c = 4'($urandom_range(0, 15));
          r = $urandom_range(0, 10);
          if (r < 9)       s = seg_tab[$urandom_range(0, 9)];
          else if (r == 9) s = seg_tab[$urandom_range(10, 15)];
          else             s = 8'($urandom_range(0, 255));
        end while (c == last_c && s == last_s);
        apply(c, s, $urandom_range(1, 10));
      end
      check_all($sformatf("rand%0d", b));
    end

    check_eq("no_err_with_fv", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
